uart_echo_fifo: RTL and testbench

//  Parametrised successor to the single-byte UART echo path. Sits between the uart core's

---
 rtl/uart_echo_fifo.sv | 147 ++++++++++++++
 tb/tb_uart_echo_fifo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_fifo.sv
// Receive-to-transmit echo path: buffers uart rx bytes in a FIFO and replays them through
// the uart transmit handshake, with a selectable byte transform and sticky status flags.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | ready to pop; sink mode drains one byte per cycle here
// WAIT_ACK  | transmit strobed, waiting for tx_busy to rise (timer running)
// WAIT_DONE | uart core is sending, waiting for tx_busy to fall

module uart_echo_fifo #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                     iCE_CLK,
    input  logic                     rst,
    input  logic                     rx_valid,
    input  logic [DATA_W-1:0]        rx_byte,
    input  logic                     rx_error,
    input  logic                     tx_busy,
    input  logic [1:0]               mode,
    input  logic                     clr_status,
    output logic                     transmit,
    output logic [DATA_W-1:0]        tx_byte,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    output logic                     ack_timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [7:0]    TIMER_LOAD = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE} state_t;

    state_t            state, state_d;
    logic [7:0]        timer, timer_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              full, empty;
    logic              pop, push, tx_load, timeout_hit;
    logic              drop_full, drop_err, drop;

    function automatic logic [DATA_W-1:0] xform(input logic [DATA_W-1:0] b,
                                                 input logic [1:0] m);
        logic [DATA_W-1:0] r;
        r = b;
        case (m)
            2'b01: if (b >= DATA_W'(8'h61) && b <= DATA_W'(8'h7A)) r = b - DATA_W'(8'h20);
            2'b10: r = ~b;
            default: r = b;
        endcase
        return r;
    endfunction

    assign full       = (count == CNT_FULL);
    assign empty      = (count == '0);
    assign fifo_count = count;

    // A full FIFO still accepts a byte when a pop frees the slot in the same cycle.
    assign push      = rx_valid & ~rx_error & (~full | pop);
    assign drop_full = rx_valid & ~rx_error & full & ~pop;
    assign drop_err  = rx_valid & rx_error;
    assign drop      = drop_full | drop_err;

    always_comb begin
        state_d     = state;
        timer_d     = timer;
        pop         = 1'b0;
        tx_load     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (mode != 2'b11) begin
                        tx_load = 1'b1;
                        timer_d = TIMER_LOAD;
                        state_d = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (timer == 8'd0) begin
                    timeout_hit = 1'b1;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer - 8'd1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCE_CLK) begin
        if (push) mem[wr_ptr] <= rx_byte;
    end

    always_ff @(posedge iCE_CLK or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            transmit    <= 1'b0;
            tx_byte     <= '0;
            overflow    <= 1'b0;
            drop_count  <= '0;
            ack_timeout <= 1'b0;
        end else begin
            state    <= state_d;
            timer    <= timer_d;
            transmit <= tx_load;
            if (tx_load) tx_byte <= xform(mem[rd_ptr], mode);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            // A drop arriving with clr_status is recorded after the clear.
            if (clr_status) begin
                overflow   <= drop_full;
                drop_count <= drop ? 8'd1 : 8'd0;
            end else begin
                if (drop_full) overflow <= 1'b1;
                if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end

            if (timeout_hit)     ack_timeout <= 1'b1;
            else if (clr_status) ack_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Scoreboard bench for uart_echo_fifo: expected tx bytes are queued at stimulus time and
// consumed by a monitor on every transmit strobe; status and timing checked directly.

module tb_uart_echo_fifo;

    logic       iCE_CLK = 1'b0;
    logic       rst;
    logic       rx_valid, rx_error, clr_status;
    logic [7:0] rx_byte;
    logic       tx_busy;
    logic [1:0] mode;
    logic       transmit;
    logic [7:0] tx_byte;
    logic [4:0] fifo_count;
    logic       overflow;
    logic [7:0] drop_count;
    logic       ack_timeout;

    logic       busy_hold, busy_resp, resp_en;
    int         busy_len;
    int         tests = 0;
    int         fails = 0;
    logic [7:0] expq[$];

    assign tx_busy = busy_hold | busy_resp;

    always #5 iCE_CLK = ~iCE_CLK;

    uart_echo_fifo #(.DATA_W(8), .DEPTH(16), .ACK_TIMEOUT(15)) dut (
        .iCE_CLK    (iCE_CLK),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .rx_error   (rx_error),
        .tx_busy    (tx_busy),
        .mode       (mode),
        .clr_status (clr_status),
        .transmit   (transmit),
        .tx_byte    (tx_byte),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .drop_count (drop_count),
        .ack_timeout(ack_timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Caller sits just after a negedge; the byte is presented for exactly one posedge.
    task automatic send(input logic [7:0] b, input bit err, input bit exp_tx,
                        input logic [7:0] exp_b);
        rx_valid = 1'b1;
        rx_byte  = b;
        rx_error = err;
        if (exp_tx) expq.push_back(exp_b);
        @(negedge iCE_CLK);
        rx_valid = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000; i++) begin
            if (expq.size() == 0 && fifo_count == 0 && tx_busy == 1'b0) break;
            @(negedge iCE_CLK);
        end
        repeat (3) @(negedge iCE_CLK);
        check("drain_queue", expq.size(), 0);
        check("drain_count", fifo_count, 0);
    endtask

    // uart core stand-in: raises tx_busy the cycle after a transmit strobe
    initial begin
        busy_resp = 1'b0;
        forever begin
            @(posedge iCE_CLK);
            #1;
            if (resp_en && transmit && !rst) begin
                busy_resp = 1'b1;
                repeat (busy_len) @(posedge iCE_CLK);
                #1;
                busy_resp = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge iCE_CLK);
            if (!rst && transmit) begin
                if (expq.size() == 0) begin
                    check("unexpected_transmit", {24'd0, tx_byte}, 32'hFFFF_FFFF);
                end else begin
                    check("tx_byte", {24'd0, tx_byte}, {24'd0, expq.pop_front()});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit early;
        rst = 1'b1; rx_valid = 1'b0; rx_error = 1'b0; rx_byte = 8'h00;
        clr_status = 1'b0; mode = 2'b00; busy_hold = 1'b0; resp_en = 1'b1; busy_len = 20;
        repeat (2) @(negedge iCE_CLK);
        check("rst_transmit", transmit, 0);
        check("rst_tx_byte", tx_byte, 0);
        check("rst_count", fifo_count, 0);
        check("rst_status", {overflow, ack_timeout, drop_count}, 0);
        rst = 1'b0;
        @(negedge iCE_CLK);

        // 1: single byte, latency and return to idle
        send(8'h41, 0, 1, 8'h41);
        check("t1_count_n1", fifo_count, 1);
        check("t1_transmit_n1", transmit, 0);
        @(negedge iCE_CLK);
        check("t1_transmit_n2", transmit, 1);
        check("t1_byte_n2", tx_byte, 8'h41);
        repeat (25) @(negedge iCE_CLK);
        check("t1_count_end", fifo_count, 0);
        check("t1_queue_end", expq.size(), 0);

        // 2: primer byte parks FSM in WAIT_DONE, then a 16-byte burst fills the FIFO
        resp_en = 1'b0;
        busy_hold = 1'b1;
        send(8'hAA, 0, 1, 8'hAA);
        for (int i = 0; i < 16; i++) send(8'(i), 0, 1, 8'(i));
        check("t2_full_count", fifo_count, 16);
        check("t2_no_overflow", overflow, 0);
        send(8'h55, 0, 0, 8'h00);
        check("t2_overflow", overflow, 1);
        check("t2_drop_count", drop_count, 1);
        check("t2_count_after_drop", fifo_count, 16);

        // 3: push lands on the same edge as the first pop out of a full FIFO
        busy_hold = 1'b0;
        resp_en = 1'b1;
        busy_len = 3;
        @(negedge iCE_CLK);
        send(8'h77, 0, 1, 8'h77);
        check("t3_count_same", fifo_count, 16);
        check("t3_no_new_drop", drop_count, 1);
        wait_drain();

        // 4: transforms
        mode = 2'b01;
        send(8'h61, 0, 1, 8'h41);
        send(8'h7A, 0, 1, 8'h5A);
        send(8'h7B, 0, 1, 8'h7B);
        send(8'h60, 0, 1, 8'h60);
        wait_drain();
        mode = 2'b10;
        send(8'h0F, 0, 1, 8'hF0);
        send(8'hA5, 0, 1, 8'h5A);
        wait_drain();
        mode = 2'b00;
        resp_en = 1'b0;
        busy_hold = 1'b1;
        send(8'h33, 0, 1, 8'h33);
        for (int i = 0; i < 4; i++) send(8'hC1 + 8'(i), 0, 0, 8'h00);
        check("t4_sink_queued", fifo_count, 4);
        mode = 2'b11;
        busy_hold = 1'b0;
        @(negedge iCE_CLK);
        check("t4_sink_idle", fifo_count, 4);
        for (int i = 1; i <= 4; i++) begin
            @(negedge iCE_CLK);
            check("t4_sink_drain", fifo_count, 4 - i);
        end
        repeat (5) @(negedge iCE_CLK);
        mode = 2'b00;

        // 5: ack timeout, then status clear and drop_count saturation
        send(8'h11, 0, 1, 8'h11);
        send(8'h22, 0, 1, 8'h22);
        check("t5_transmit", transmit, 1);
        early = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge iCE_CLK);
            if (ack_timeout) early = 1'b1;
        end
        check("t5_timeout_early", early, 0);
        @(negedge iCE_CLK);
        check("t5_timeout_set", ack_timeout, 1);
        @(negedge iCE_CLK);
        check("t5_next_transmit", transmit, 1);
        repeat (20) @(negedge iCE_CLK);
        check("t5_queue_empty", expq.size(), 0);
        clr_status = 1'b1;
        @(negedge iCE_CLK);
        clr_status = 1'b0;
        check("t5_cleared", {overflow, ack_timeout, drop_count}, 0);
        for (int i = 0; i < 254; i++) send(8'h99, 1, 0, 8'h00);
        check("t5_drop_254", drop_count, 254);
        send(8'h99, 1, 0, 8'h00);
        check("t5_drop_255", drop_count, 255);
        for (int i = 0; i < 45; i++) send(8'h99, 1, 0, 8'h00);
        check("t5_drop_sat", drop_count, 255);
        check("t5_err_no_push", fifo_count, 0);
        check("t5_err_no_overflow", overflow, 0);
        clr_status = 1'b1;
        send(8'h99, 1, 0, 8'h00);
        clr_status = 1'b0;
        check("t5_clr_with_drop", drop_count, 1);

        // 6: reset while the uart core is busy with 5 bytes still queued
        resp_en = 1'b1;
        busy_len = 20;
        send(8'h01, 0, 1, 8'h01);
        for (int i = 2; i <= 6; i++) send(8'(i), 0, 0, 8'h00);
        check("t6_queued", fifo_count, 5);
        rst = 1'b1;
        #1;
        check("t6_rst_count", fifo_count, 0);
        check("t6_rst_outputs", {transmit, tx_byte, overflow, ack_timeout, drop_count}, 0);
        @(negedge iCE_CLK);
        rst = 1'b0;
        repeat (40) @(negedge iCE_CLK);
        check("t6_count_after", fifo_count, 0);
        check("t6_queue_after", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
